time_counter: RTL
=================

Name: time_counter

Overview:
- BCD hours:minutes:seconds timekeeping core for the digital clock.
- Sits directly downstream of the clock divider and consumes its CP_1Hz output as a count tick.
- Provides manual minute/hour adjustment and a hold control.
- Produces registered BCD time and carry pulses for the display and alarm stages.

Parameters:
- INIT_HOUR, 8'h00, BCD hour (00-23) loaded on reset.
- INIT_MIN, 8'h00, BCD minute (00-59) loaded on reset.
- INIT_SEC, 8'h00, BCD second (00-59) loaded on reset.
- Parameters must be valid BCD within range. The block does not check them.

Ports:
- CP  input  1  system clock; the only clock in the block.
- CR  input  1  reset; synchronous, active-high.
- tick_1hz  input  1  CP_1Hz from the divider; level input, rising edge detected internally.
- hold  input  1  when 1, seconds do not advance; adjustments still apply.
- adj_min  input  1  one-cycle pulse; minute +1.
- adj_hour  input  1  one-cycle pulse; hour +1.
- Hour  output  8  BCD hour {tens[7:4], units[3:0]}, registered.
- Minute  output  8  BCD minute, registered.
- Second  output  8  BCD second, registered.
- min_tick  output  1  one-cycle pulse on a seconds 59->00 carry.
- hour_tick  output  1  one-cycle pulse on a minutes 59->00 carry.
- day_tick  output  1  one-cycle pulse on a 23:59:59->00:00:00 carry.

Behaviour:
- Everything updates on the CP rising edge only.
- Reset (CR=1 at a CP edge):
  - Hour=INIT_HOUR, Minute=INIT_MIN, Second=INIT_SEC.
  - All tick outputs = 0.
  - Edge register tick_d = 1, so a tick_1hz already high at reset release is not counted.
  - Reset overrides every other input, including mid-carry.
- Edge detect: rise = tick_1hz & ~tick_d; tick_d <= tick_1hz every cycle.
  - Second updates on the same CP edge that samples rise=1.
  - Latency is 1 CP cycle from tick_1hz going high to the new value on Second.
  - A tick_1hz held high for many cycles counts once.
- Seconds: if rise & ~hold, Second = Second+1 in BCD.
  - Units 9 -> 0 with a tens increment.
  - 59 -> 00 generates the seconds carry (sc).
- Minutes: advance on sc, or on adj_min.
  - 59 -> 00 by sc generates the minute carry (mc).
  - adj_min wraps 59 -> 00 without carrying into Hour.
- Hours: advance on mc, or on adj_hour.
  - 23 -> 00 by mc generates day_tick.
  - adj_hour wraps 23 -> 00 without day_tick.
- Tick outputs are registered and asserted in the same cycle the wrapped value appears.
  - min_tick=sc, hour_tick=mc (sc & Minute==59), day_tick=mc & Hour==23.
  - All are low in every other cycle.
- Simultaneous events:
  - adj_min and sc in the same cycle: Minute +1 only. sc is dropped; no mc and no hour_tick. Second still wraps and min_tick still pulses.
  - adj_hour and mc in the same cycle: Hour +1 only. mc is dropped; no day_tick. hour_tick still pulses.
  - adj_min and adj_hour together: both fields advance independently.
  - hold=1 and rise=1: the tick is consumed (tick_d updates) and not replayed after hold drops.
- BCD digits never take the values A-F during normal operation.

Optional Feature:
- Macro: TWELVE_HOUR_EN.
- Defined:
  - The internal hour register stays 24-hour.
  - Hour output is a combinational remap of that register: 00->12, 01-11 unchanged, 12->12, 13-23 -> 01-11.
  - An extra output port PM (1 bit) is 1 when the internal hour is 12-23.
  - Carry and adjust rules are unchanged and operate on the internal 24-hour value.
- Undefined: the PM port is absent and Hour is the raw 24-hour BCD value.

Test Plan:
- Reset with defaults, then drive 61 tick_1hz rising edges (tick high 3 cycles each) -> Second=01, Minute=01, exactly one min_tick pulse, coincident with Second=00.
- INIT 23:59:58, two ticks -> 23:59:59, then 00:00:00; min_tick, hour_tick and day_tick all pulse in the same single cycle.
- Hold tick_1hz high for 100 cycles after reset -> Second stays 00 (reset edge suppression), then one fresh rising edge -> Second=01.
- INIT 10:59:59, pulse adj_min in the same cycle as the tick rise -> 10:00:00, min_tick=1, hour_tick=0. Separately, adj_hour at Hour=23 -> 00 with day_tick=0.
- hold=1 across 5 ticks with 2 adj_min pulses from 00:00:00 -> 00:02:00. Release hold, one tick -> 00:02:01.
- With TWELVE_HOUR_EN defined, sweep the internal hour through 00, 11, 12 and 13 -> Hour/PM = 12/0, 11/0, 12/1, 01/1.

Source files
------------

// File: rtl/time_counter.sv
// BCD hh:mm:ss timekeeping core, advanced by rising edges of the divider's 1 Hz level.
// Optional build macro TWELVE_HOUR_EN adds a 12-hour Hour remap and a PM output.
module time_counter #(
    parameter logic [7:0] INIT_HOUR = 8'h00,
    parameter logic [7:0] INIT_MIN  = 8'h00,
    parameter logic [7:0] INIT_SEC  = 8'h00
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       tick_1hz,
    input  logic       hold,
    input  logic       adj_min,
    input  logic       adj_hour,
    output logic [7:0] Hour,
    output logic [7:0] Minute,
    output logic [7:0] Second,
    output logic       min_tick,
    output logic       hour_tick,
    output logic       day_tick
`ifdef TWELVE_HOUR_EN
    ,
    output logic       PM
`endif
);

    logic       tick_prev_q, tick_prev_d;
    logic [7:0] sec_q, sec_d;
    logic [7:0] min_q, min_d;
    logic [7:0] hour_q, hour_d;
    logic       min_tick_q, min_tick_d;
    logic       hour_tick_q, hour_tick_d;
    logic       day_tick_q, day_tick_d;

    logic rise;
    logic sec_adv;
    logic sc;
    logic mc;

    // Two-digit BCD increment that wraps to 00 after max_val.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max_val);
        logic [7:0] res;
        if (val == max_val) begin
            res = '0;
        end else if (val[3:0] == 4'd9) begin
            res = {val[7:4] + 4'd1, 4'd0};
        end else begin
            res = {val[7:4], val[3:0] + 4'd1};
        end
        return res;
    endfunction

    always_comb begin
        rise        = tick_1hz & ~tick_prev_q;
        sec_adv     = rise & ~hold;
        sc          = sec_adv & (sec_q == 8'h59);
        // A manual minute step swallows the seconds carry, so no minute carry can follow.
        mc          = sc & ~adj_min & (min_q == 8'h59);

        tick_prev_d = tick_1hz;
        sec_d       = sec_adv ? bcd_inc(sec_q, 8'h59) : sec_q;
        min_d       = (adj_min | sc) ? bcd_inc(min_q, 8'h59) : min_q;
        hour_d      = (adj_hour | mc) ? bcd_inc(hour_q, 8'h23) : hour_q;

        min_tick_d  = sc;
        hour_tick_d = mc;
        day_tick_d  = mc & ~adj_hour & (hour_q == 8'h23);
    end

    always_ff @(posedge CP) begin
        if (CR) begin
            // Treat the 1 Hz line as already high so a level present at release is ignored.
            tick_prev_q <= 1'b1;
            sec_q       <= INIT_SEC;
            min_q       <= INIT_MIN;
            hour_q      <= INIT_HOUR;
            min_tick_q  <= 1'b0;
            hour_tick_q <= 1'b0;
            day_tick_q  <= 1'b0;
        end else begin
            tick_prev_q <= tick_prev_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            min_tick_q  <= min_tick_d;
            hour_tick_q <= hour_tick_d;
            day_tick_q  <= day_tick_d;
        end
    end

    assign Second    = sec_q;
    assign Minute    = min_q;
    assign min_tick  = min_tick_q;
    assign hour_tick = hour_tick_q;
    assign day_tick  = day_tick_q;

`ifdef TWELVE_HOUR_EN
    logic [4:0] hour_bin;
    logic [4:0] hour_12;
    logic [3:0] hour_units;

    // Internal hour stays 24-hour; only the presented value is folded to 1..12.
    always_comb begin
        hour_bin = 5'd10 * {3'b000, hour_q[5:4]} + {1'b0, hour_q[3:0]};
        if (hour_bin == 5'd0) begin
            hour_12 = 5'd12;
        end else if (hour_bin > 5'd12) begin
            hour_12 = hour_bin - 5'd12;
        end else begin
            hour_12 = hour_bin;
        end
        hour_units = hour_12[3:0] - 4'd10;
        Hour       = (hour_12 >= 5'd10) ? {4'h1, hour_units} : {4'h0, hour_12[3:0]};
        PM         = (hour_bin >= 5'd12);
    end
`else
    assign Hour = hour_q;
`endif

endmodule
